// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;
    localparam int DIV_WIDTH_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;
endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle for seq_divider; master issues divisions, slave computes them.
interface seq_divider_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
);
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider_trial_sub.sv
// Combinational trial subtractor: diff = a - b as a + ~b + 1; borrow_o is the result sign bit.
module div_trial_sub #(
    parameter int W = 5
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    output logic [W-1:0] diff_o,
    output logic         borrow_o
);
    logic [W-1:0] b_inv;

    genvar gi;
    generate
        for (gi = 0; gi < W; gi++) begin : g_inv
            assign b_inv[gi] = ~b_i[gi];
        end
    endgenerate

    assign diff_o   = a_i + b_inv + W'(1);
    assign borrow_o = diff_o[W-1];
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Define SIGNED_DIV_EN to treat operands as two's complement (truncating toward zero).
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    seq_divider_if.slave bus
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    div_state_e       state_q;
    logic [WIDTH:0]   r_q;
    logic [WIDTH-1:0] q_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] divisor_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quot_q;
    logic [WIDTH-1:0] rem_q;
    logic             dz_q;

    logic [WIDTH:0]   rs;
    logic [WIDTH:0]   t;
    logic             t_neg;
    logic [WIDTH:0]   r_d;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    assign rs = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

    div_trial_sub #(.W(WIDTH + 1)) u_trial (
        .a_i      (rs),
        .b_i      ({1'b0, divisor_q}),
        .diff_o   (t),
        .borrow_o (t_neg)
    );

    assign r_d = t_neg ? rs : t;
    assign q_d = {q_q[WIDTH-2:0], ~t_neg};

`ifdef SIGNED_DIV_EN
    logic qneg_q;
    logic rneg_q;

    // Magnitude of the most-negative value wraps to itself, which reads correctly as unsigned.
    assign a_mag    = bus.dividend[WIDTH-1] ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
    assign b_mag    = bus.divisor[WIDTH-1]  ? (~bus.divisor  + WIDTH'(1)) : bus.divisor;
    assign quot_fix = qneg_q ? (~q_d + WIDTH'(1)) : q_d;
    assign rem_fix  = rneg_q ? (~r_d[WIDTH-1:0] + WIDTH'(1)) : r_d[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else if (state_q == IDLE && bus.start) begin
            qneg_q <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
            rneg_q <= bus.dividend[WIDTH-1];
        end
    end
`else
    assign a_mag    = bus.dividend;
    assign b_mag    = bus.divisor;
    assign quot_fix = q_d;
    assign rem_fix  = r_d[WIDTH-1:0];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            r_q       <= '0;
            q_q       <= '0;
            cnt_q     <= '0;
            divisor_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quot_q    <= '0;
            rem_q     <= '0;
            dz_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        divisor_q <= b_mag;
                        q_q       <= a_mag;
                        r_q       <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        if (bus.divisor == '0) begin
                            state_q <= DONE;
                            quot_q  <= '1;
                            rem_q   <= bus.dividend;
                            dz_q    <= 1'b1;
                        end else begin
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_q   <= r_d;
                    q_q   <= q_d;
                    cnt_q <= cnt_q + CW'(1);
                    // Final iteration: results (with sign fix-up) land on the DONE-entry edge.
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        state_q <= DONE;
                        quot_q  <= quot_fix;
                        rem_q   <= rem_fix;
                        dz_q    <= 1'b0;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dz_q;
endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Multi-cycle restoring divider. Its datapath is the trial-subtract step of the team's 4-bit add/subtract unit, run in the inverse direction: division by repeated shift-and-subtract.
- Accepts dividend/divisor on a start pulse and iterates one quotient bit per clock.
- Returns quotient, remainder and a divide-by-zero flag with a one-cycle done pulse.
- Sits beside the combinational adder/subtractor as the team's first sequential arithmetic unit.

Parameters:
WIDTH, 4, operand/quotient/remainder width in bits (min 2).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
start  input  1  request; sampled only in IDLE
dividend  input  WIDTH  numerator, captured when start accepted
divisor  input  WIDTH  denominator, captured when start accepted
busy  output  1  high in CALC and DONE states
done  output  1  one-cycle pulse, results valid
quotient  output  WIDTH  registered result, held until next accepted start
remainder  output  WIDTH  registered result, held until next accepted start
div_by_zero  output  1  registered flag, updated with results

Behaviour:
- Clock and reset
  - One clock. Reset is synchronous and active-high on rst.
  - rst=1 at any edge, including mid-CALC, forces IDLE.
  - Reset clears busy, done, quotient, remainder, div_by_zero and the iteration counter to 0.
- States: IDLE, CALC, DONE (2-bit encoding).
- IDLE
  - start=1 captures the operands and clears partial remainder R (WIDTH+1 bits).
  - Loads Q=dividend and count=0.
  - Next state is CALC, or DONE if divisor==0.
- CALC: one iteration per edge.
  - Rs={R[WIDTH-1:0],Q[WIDTH-1]}.
  - T=Rs-{1'b0,divisor}, computed at WIDTH+1 bits.
  - If T[WIDTH]==0: R=T and Q={Q[WIDTH-2:0],1}.
  - Else: R=Rs and Q={Q[WIDTH-2:0],0}.
  - count increments. On the edge completing iteration WIDTH, load quotient=Q and remainder=R[WIDTH-1:0], and go to DONE.
- DONE
  - done=1 for exactly one cycle, then IDLE.
  - start asserted in CALC or DONE is ignored and not queued.
- Latency
  - Start sampled at edge 0; done is high during the cycle after edge WIDTH+1.
  - Back-to-back: the next start is accepted at the edge where the state is IDLE again, giving a throughput of one division per WIDTH+2 cycles.
- Divide by zero: IDLE to DONE directly, with quotient={WIDTH{1}}, remainder=dividend and div_by_zero=1. div_by_zero is cleared on the next accepted non-zero start.
- Boundaries
  - dividend<divisor gives quotient 0 and remainder=dividend.
  - dividend==0 gives 0,0.
  - Max/1 gives max,0.
  - Result registers never change outside the DONE-entry edge or reset.

Optional Feature:
SIGNED_DIV_EN
- Defined: operands are two's complement.
  - The IDLE capture takes magnitudes, and the sign flags are registered.
  - The quotient is negated if the signs differ; the remainder takes the dividend's sign; truncation is toward zero.
  - Overflow (most-negative / -1) yields quotient=most-negative, remainder=0, no flag.
  - Divide by zero behaves as in unsigned mode.
  - Sign fix-up is applied on the DONE-entry edge, so latency is unchanged.
- Undefined: unsigned only; no sign logic is synthesised.

Decomposition:
- Package div_pkg: state typedef (IDLE/CALC/DONE) and a DIV_WIDTH_DEFAULT=4 constant.
- One sub-module, div_trial_sub: combinational (WIDTH+1)-bit subtractor returning the difference and the sign/borrow bit.
  - Mirrors the existing add/subtract unit's two's-complement subtract (invert plus carry-in 1).
- The FSM, counter and shift registers stay in seq_divider.

Test Plan:
- WIDTH=4, reset then start with 13/3 -> busy rises next cycle; done in the 6th cycle after the start edge; quotient=4, remainder=1, div_by_zero=0.
- 15/1 then immediate back-to-back 3/7 -> 15,0 then 0,3; a start pulse held during CALC causes no extra done.
- 5/0 -> done one cycle after entering DONE (2 edges); quotient=1111, remainder=0101, div_by_zero=1. The following 9/2 -> 4,1 with div_by_zero=0.
- 12/5 with rst pulsed at the 2nd CALC cycle -> all outputs 0, state IDLE, no done. A fresh 12/5 -> 2,2.
- Random sweep of all 256 operand pairs against a reference model (quotient*divisor+remainder==dividend, remainder<divisor).
- SIGNED_DIV_EN: -7/2 -> quotient=1101 (-3), remainder=1111 (-1); -8/-1 -> quotient=1000, remainder=0000.
